// File: rtl/tcp_slice_chain.sv
// Width-generic AXI4-Stream register-slice chain: full-skid, forward-only or bypass
// architecture, with occupancy and transfer-count status outputs.
module tcp_slice_chain #(
  parameter int N_STAGES  = 2,
  parameter int DATA_BITS = 512,
  parameter int KEEP_EN   = 1,
  parameter int ID_BITS   = 6,
  parameter int LAST_EN   = 1,
  parameter int MODE      = 0,
  parameter int CNT_BITS  = 32
) (
  input  logic                                  aclk,
  input  logic                                  areset,
  input  logic                                  s_axis_tvalid,
  output logic                                  s_axis_tready,
  input  logic [DATA_BITS-1:0]                  s_axis_tdata,
  input  logic [DATA_BITS/8-1:0]                s_axis_tkeep,
  input  logic [(ID_BITS > 0 ? ID_BITS : 1)-1:0] s_axis_tid,
  input  logic                                  s_axis_tlast,
  output logic                                  m_axis_tvalid,
  input  logic                                  m_axis_tready,
  output logic [DATA_BITS-1:0]                  m_axis_tdata,
  output logic [DATA_BITS/8-1:0]                m_axis_tkeep,
  output logic [(ID_BITS > 0 ? ID_BITS : 1)-1:0] m_axis_tid,
  output logic                                  m_axis_tlast,
  output logic [$clog2(2*N_STAGES+1)-1:0]       occupancy,
  output logic [CNT_BITS-1:0]                   xfer_cnt
);

  localparam int KW = (KEEP_EN != 0) ? DATA_BITS / 8 : 0;
  localparam int IW = (ID_BITS > 0) ? ID_BITS : 0;
  localparam int LW = (LAST_EN != 0) ? 1 : 0;
  localparam int PW = DATA_BITS + KW + IW + LW;
  localparam int OW = $clog2(2 * N_STAGES + 1);

  logic [PW-1:0]       s_pay, m_pay;
  logic                s_fire, m_fire;
  logic [OW-1:0]       occ_q;
  logic [CNT_BITS-1:0] cnt_q;

  // Disabled sideband fields never reach storage; their outputs are tied to fixed values.
  assign s_pay[DATA_BITS-1:0] = s_axis_tdata;
  assign m_axis_tdata         = m_pay[DATA_BITS-1:0];

  if (KW > 0) begin : g_keep
    assign s_pay[DATA_BITS +: KW] = s_axis_tkeep;
    assign m_axis_tkeep           = m_pay[DATA_BITS +: KW];
  end else begin : g_nokeep
    assign m_axis_tkeep = '1;
  end

  if (IW > 0) begin : g_id
    assign s_pay[DATA_BITS+KW +: IW] = s_axis_tid;
    assign m_axis_tid                = m_pay[DATA_BITS+KW +: IW];
  end else begin : g_noid
    assign m_axis_tid = '0;
  end

  if (LW > 0) begin : g_last
    assign s_pay[PW-1]  = s_axis_tlast;
    assign m_axis_tlast = m_pay[PW-1];
  end else begin : g_nolast
    assign m_axis_tlast = 1'b1;
  end

  if (MODE == 2) begin : g_bypass
    assign m_pay         = s_pay;
    assign m_axis_tvalid = s_axis_tvalid;
    assign s_axis_tready = m_axis_tready;
  end else begin : g_pipe
    logic              rdy_en;
    logic [N_STAGES:0] vld_p;
    logic [N_STAGES:0] rdy_p;
    logic [PW-1:0]     pay_p [N_STAGES+1];

    // rdy_en keeps the input closed during reset and opens it one cycle after release.
    always_ff @(posedge aclk) begin
      if (areset) rdy_en <= 1'b0;
      else        rdy_en <= 1'b1;
    end

    assign vld_p[0]          = s_axis_tvalid && rdy_en;
    assign pay_p[0]          = s_pay;
    assign rdy_p[N_STAGES]   = m_axis_tready;
    assign s_axis_tready     = rdy_en && rdy_p[0];
    assign m_axis_tvalid     = vld_p[N_STAGES];
    assign m_pay             = pay_p[N_STAGES];

    for (genvar i = 0; i < N_STAGES; i++) begin : g_stage
      if (MODE == 0) begin : g_skid
        logic          main_vld_p, skid_vld_p;
        logic [PW-1:0] main_pay_p, skid_pay_p;
        logic          in_fire, out_fire;

        assign in_fire  = vld_p[i] && !skid_vld_p;
        assign out_fire = main_vld_p && rdy_p[i+1];

        // ---- stage i: main/skid pair, ready taken straight from the skid flop ----
        always_ff @(posedge aclk) begin
          if (areset) begin
            main_vld_p <= 1'b0;
            skid_vld_p <= 1'b0;
          end else if (out_fire) begin
            main_vld_p <= skid_vld_p || in_fire;
            skid_vld_p <= 1'b0;
          end else if (in_fire) begin
            main_vld_p <= 1'b1;
            skid_vld_p <= main_vld_p;
          end
        end

        always_ff @(posedge aclk) begin
          if (out_fire)                     main_pay_p <= skid_vld_p ? skid_pay_p : pay_p[i];
          else if (in_fire && !main_vld_p)  main_pay_p <= pay_p[i];
          if (in_fire && main_vld_p && !out_fire) skid_pay_p <= pay_p[i];
        end

        assign rdy_p[i]     = !skid_vld_p;
        assign vld_p[i+1]   = main_vld_p;
        assign pay_p[i+1]   = main_pay_p;
      end else begin : g_fwd
        logic          fwd_vld_p;
        logic [PW-1:0] fwd_pay_p;

        // Ready looks ahead over all later stages instead of chaining stage to stage.
        assign rdy_p[i] = m_axis_tready || !(&vld_p[N_STAGES:i+1]);

        // ---- stage i: single forward register ----
        always_ff @(posedge aclk) begin
          if (areset)        fwd_vld_p <= 1'b0;
          else if (rdy_p[i]) fwd_vld_p <= vld_p[i];
        end

        always_ff @(posedge aclk) begin
          if (rdy_p[i] && vld_p[i]) fwd_pay_p <= pay_p[i];
        end

        assign vld_p[i+1] = fwd_vld_p;
        assign pay_p[i+1] = fwd_pay_p;
      end
    end
  end

  assign s_fire = s_axis_tvalid && s_axis_tready;
  assign m_fire = m_axis_tvalid && m_axis_tready;

  always_ff @(posedge aclk) begin
    if (areset) begin
      occ_q <= '0;
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_BITS'(m_fire);
      if (s_fire && !m_fire)      occ_q <= occ_q + OW'(1);
      else if (m_fire && !s_fire) occ_q <= occ_q - OW'(1);
    end
  end

  assign occupancy = (MODE == 2) ? '0 : occ_q;
  assign xfer_cnt  = cnt_q;

endmodule

// File: doc/tcp_slice_chain.md
Name: tcp_slice_chain

Overview:
- Parametrised, width-generic register-slice pipeline for one AXI4-Stream or meta channel; successor to the fixed-width per-channel TCP slice instances.
- Inserted between the network stack and user logic (or across SLR boundaries) for timing closure.
- Runtime-invisible choice of slice architecture via MODE; exports occupancy and a transfer counter for debug/status.

Parameters:
- N_STAGES, 2, number of slice stages in series (1..8); ignored when MODE=2.
- DATA_BITS, 512, tdata width (8..1024); meta channels use their struct width.
- KEEP_EN, 1, 1 = carry tkeep (DATA_BITS/8 bits); 0 = m_axis_tkeep driven all-ones.
- ID_BITS, 6, tid width (0 = tid absent; m_axis_tid driven 0).
- LAST_EN, 1, 1 = carry tlast; 0 = m_axis_tlast driven 1.
- MODE, 0, 0 = full skid (all outputs and ready registered); 1 = forward-only (data/valid registered, ready combinational); 2 = bypass (pure wires).
- CNT_BITS, 32, transfer counter width.

Ports:
- aclk  in  1  clock.
- areset  in  1  synchronous active-high reset.
- s_axis_tvalid  in  1  upstream valid.
- s_axis_tready  out  1  upstream ready.
- s_axis_tdata  in  DATA_BITS  upstream data.
- s_axis_tkeep  in  DATA_BITS/8  upstream keep.
- s_axis_tid  in  max(ID_BITS,1)  upstream id.
- s_axis_tlast  in  1  upstream last.
- m_axis_tvalid  out  1  downstream valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tdata  out  DATA_BITS  downstream data.
- m_axis_tkeep  out  DATA_BITS/8  downstream keep.
- m_axis_tid  out  max(ID_BITS,1)  downstream id.
- m_axis_tlast  out  1  downstream last.
- occupancy  out  clog2(2*N_STAGES+1)  beats currently held in the chain.
- xfer_cnt  out  CNT_BITS  beats accepted at the m side since reset; wraps.

Behaviour:
- Transfer occurs on a side when valid && ready at a rising aclk edge. The block never drops, duplicates or reorders beats.
- Payload = {tdata, tkeep, tid, tlast}, with disabled fields removed from storage.

MODE 0, per stage:
- Main register plus skid register.
- s_ready of a stage = !skid_valid, registered.
- Accept when main is empty, or when main is draining this cycle: load main.
- Accept when main is full and not draining: load skid.
- On drain: skid moves to main.
- Full throughput (1 beat/cycle) in steady flow; latency 1 cycle per stage.
- No combinational path between any s_* and any m_* port.

MODE 1, per stage:
- Single register; s_ready = !valid || next_ready (combinational).
- Latency 1 cycle/stage; full throughput.
- Combinational ready path through the whole chain.

MODE 2:
- m_* = s_*, s_axis_tready = m_axis_tready.
- occupancy = 0; xfer_cnt still counts.

Latency:
- MODE 0/1: first beat into an empty chain appears at m_axis_tvalid exactly N_STAGES cycles after the s-side transfer.

Capacity:
- MODE 0: 2*N_STAGES beats.
- MODE 1: N_STAGES beats.
- When full, s_axis_tready = 0 (MODE 0: deasserted the cycle after the filling transfer; no beat is lost).

Occupancy:
- Registered; +1 on s transfer, -1 on m transfer; unchanged on simultaneous transfers.
- Never exceeds capacity, never underflows.

xfer_cnt:
- Increments on each m transfer; 2^CNT_BITS-1 wraps to 0.

Reset:
- While areset=1: all stage valids cleared, m_axis_tvalid=0, s_axis_tready=0 (MODE 0/1), occupancy=0, xfer_cnt=0.
- m_axis_tdata/tkeep/tid/tlast are don't-care while invalid.
- s_axis_tready rises the first cycle after areset falls.
- Reset mid-packet discards all held beats; no partial beat emerges afterwards.

Backpressure stability:
- While m_axis_tvalid=1 and m_axis_tready=0, every m_axis_* payload field holds stable.

Test Plan:
- MODE 0, N_STAGES=2, m_ready=1, send beats tdata=0..99 back-to-back -> first beat out 2 cycles after input; 100 beats in order, 1/cycle; xfer_cnt=100; occupancy returns to 0.
- MODE 0, N_STAGES=3, m_ready=0, s_valid held high -> exactly 6 beats accepted; s_axis_tready=0 from the following cycle; occupancy=6. Release ready -> 6 beats out in order, stable while stalled.
- MODE 1, N_STAGES=2, random 30% m_ready, 1000 random beats with tkeep/tid/tlast -> scoreboard matches exactly; occupancy never >2.
- MODE 2, any N_STAGES -> m_* equal s_* in the same cycle; s_axis_tready tracks m_axis_tready; occupancy=0.
- Assert areset for 1 cycle with 4 beats held (MODE 0, N_STAGES=2) -> next cycle m_axis_tvalid=0, occupancy=0, xfer_cnt=0; no stale beat emitted afterwards.
- CNT_BITS=4, 17 beats transferred -> xfer_cnt wraps to 1.
